mem_responder: RTL and testbench
================================

# mem_responder

Multicycle memory responder that serves the processor's memory requests: instruction fetch and data load/store through a single request/ready handshake. It latches each request, inserts a configurable number of wait states, then performs the access on a word-organised array. It returns one `Ready` pulse, with read data for loads. It sits between the processor top and its unified instruction/data storage, and stands in for a slow external memory.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, 4..65536.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; 0..15.
- `Clk` input 1: single clock; all state changes on rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `Req` input 1: request valid; held high by requester until `Ready` is seen.
- `WE` input 1: 1 = write (store), 0 = read (fetch/load).
- `Addr` input 32: byte address.
- `WData` input 32: store data.
- `Ready` output 1: one-cycle response pulse.
- `RData` output 32: read data, registered, valid while `Ready` = 1 and held afterwards.
- `Err` output 1: misaligned-access flag, qualified by `Ready` (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A rising edge with `Req` = 1 accepts the request.
  - `WE`, `Addr` and `WData` are latched at that edge.
  - Wait counter loads `WAIT_CYCLES`.
  - Next state is WAIT, or RESP if `WAIT_CYCLES` = 0.
- WAIT: counter decrements each edge; moves to RESP on the edge where the counter reaches 1. No input is sampled.
- RESP: `Ready` = 1 for exactly this cycle; unconditional return to IDLE.
- Write access: array word updated with the latched `WData` at the accept edge. `RData` is unchanged by writes.
- Read access: `RData` loaded from the array at the edge entering RESP. A write accepted earlier is therefore always visible to a later read.
- Word index = latched `Addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses beyond the array alias and wrap modulo `DEPTH_WORDS`.
- `Req` or input changes while in WAIT or RESP are ignored. Inputs are latched, so a mid-transaction address change has no effect.
- `Req` still high in the IDLE cycle after RESP is treated as a new request. Requesters must drop `Req` at the edge that ends RESP.
- Array contents are not reset; simulation initial contents are undefined unless preloaded by the bench.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `Ready` = 0, `RData` = 32'h0000_0000, `Err` = 0.
- Latency: with the accept edge at t0, `Ready` is high in the cycle after edge t0+`WAIT_CYCLES`, i.e. `WAIT_CYCLES`+1 cycles after acceptance.
- Throughput: one transaction per `WAIT_CYCLES`+2 cycles. The mandatory IDLE cycle after RESP separates transactions.
- Reset mid-operation:
  - FSM returns to IDLE immediately and `Ready` is forced to 0.
  - A write already accepted stays committed.
  - A pending read is abandoned with no response.
- `Ready`, `RData` and `Err` are all register outputs; there is no combinational path from any input.

## Configuration
- Macro `MEM_MISALIGN_ERR_EN`.
- Defined:
  - Latched `Addr[1:0]` ≠ 0 marks the access misaligned.
  - A misaligned write is suppressed and the array is left unchanged.
  - A misaligned read loads `RData` = 32'h0000_0000.
  - `Err` = 1 during the RESP cycle, 0 otherwise. Latency is unchanged.
- Undefined: `Addr[1:0]` is ignored (word-truncated access), `Err` is tied to 0, and no misalignment logic is generated.

## Test plan
- Reset: assert `Rst` mid-WAIT of a read at 0x10 → `Ready` stays 0, `RData` = 0, FSM in IDLE; next request is served normally.
- Write then read, `WAIT_CYCLES` = 2: store 0xDEADBEEF at 0x40, then load 0x40 → `Ready` high 3 cycles after each accept, `RData` = 0xDEADBEEF.
- `WAIT_CYCLES` = 0: load at 0x0 accepted at t0 → `Ready` in the very next cycle; back-to-back requests are accepted every 2 cycles.
- Wrap-around, `DEPTH_WORDS` = 256: store 0x12345678 at 0x400, load 0x000 → `RData` = 0x12345678.
- Ignore while busy: during WAIT, change `Addr` to 0x80 and `WE` to 1 → the original read of 0x40 completes and the word at 0x80 is unchanged.
- `MEM_MISALIGN_ERR_EN`: store to 0x42 → `Err` = 1 with `Ready`, word at 0x40 unchanged. Without the macro, the same store writes word 0x40 and `Err` = 0.

Source files
------------

// File: rtl/mem_responder.sv
// Multicycle word-organised memory responder with a Req/Ready handshake and programmable wait states.
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_ERR_EN.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        WE,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic [31:0] RData,
    output logic        Err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nxt_s;
    logic            accept_s;
    logic            to_resp_s;
    logic            we_r;
    logic [AW-1:0]   idx_r;
    logic [AW-1:0]   addr_idx_s;
    logic [AW-1:0]   rd_idx_s;
    logic            rd_we_s;
    logic            wr_en_s;
    logic            rd_misalign_s;
    logic [31:0]     rd_word_s;
    logic [31:0]     mem_r [DEPTH_WORDS];
    logic            unused_addr_s;

    assign addr_idx_s    = Addr[AW+1:2];
    assign unused_addr_s = ^{Addr[31:AW+2], Addr[1:0]};

    // With zero wait states the read happens on the accept edge, so the live inputs are used there.
    assign rd_idx_s  = (state_r == ST_IDLE) ? addr_idx_s : idx_r;
    assign rd_we_s   = (state_r == ST_IDLE) ? WE : we_r;
    assign rd_word_s = mem_r[rd_idx_s];

`ifdef MEM_MISALIGN_ERR_EN
    logic misalign_in_s;
    logic misalign_r;

    assign misalign_in_s = (Addr[1:0] != 2'b00);
    assign rd_misalign_s = (state_r == ST_IDLE) ? misalign_in_s : misalign_r;
    assign wr_en_s       = accept_s & WE & ~misalign_in_s & ~Rst;

    // Misalignment flag captured with the request
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            misalign_r <= 1'b0;
        end else if (accept_s) begin
            misalign_r <= misalign_in_s;
        end
    end
`else
    assign rd_misalign_s = 1'b0;
    assign wr_en_s       = accept_s & WE & ~Rst;
`endif

    // Next-state, wait counter and handshake decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        to_resp_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Req) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = WAIT_LOAD;
                    if (WAIT_LOAD == 4'd0) begin
                        state_nxt_s = ST_RESP;
                        to_resp_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_RESP;
                    cnt_nxt_s   = 4'd0;
                    to_resp_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request latch and registered response outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            we_r  <= 1'b0;
            idx_r <= '0;
            Ready <= 1'b0;
            RData <= 32'h0000_0000;
            Err   <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r  <= WE;
                idx_r <= addr_idx_s;
            end
            Ready <= to_resp_s;
            Err   <= to_resp_s & rd_misalign_s;
            if (to_resp_s && !rd_we_s) begin
                RData <= rd_misalign_s ? 32'h0000_0000 : rd_word_s;
            end
        end
    end

    // Storage array: not reset, written on the accept edge
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            mem_r[addr_idx_s] <= WData;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: one instance with two wait states, one with none,
// both compared against an array-based reference model.
module tb_mem_responder;
    localparam int DEPTH = 256;
    localparam int WC0   = 2;
    localparam int WC1   = 0;
`ifdef MEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk_s = 1'b0;
    logic        rst_s = 1'b1;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        ready0_s, ready1_s, err0_s, err1_s;
    logic [31:0] rdata0_s, rdata1_s;
    int          cyc_r = 0;
    int          total_s = 0;
    int          bad_s = 0;

    logic [31:0] ref_mem   [2][DEPTH];
    bit          ref_vld   [2][DEPTH];
    logic [31:0] exp_rd    [2];
    bit          exp_rd_ok [2];

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC0)) dut0 (
        .Clk(clk_s), .Rst(rst_s), .Req(req_s[0]), .WE(we_s[0]), .Addr(addr_s[0]),
        .WData(wdata_s[0]), .Ready(ready0_s), .RData(rdata0_s), .Err(err0_s)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC1)) dut1 (
        .Clk(clk_s), .Rst(rst_s), .Req(req_s[1]), .WE(we_s[1]), .Addr(addr_s[1]),
        .WData(wdata_s[1]), .Ready(ready1_s), .RData(rdata1_s), .Err(err1_s)
    );

    always #5 clk_s = ~clk_s;

    always @(posedge clk_s) cyc_r <= cyc_r + 1;

    function automatic int wc(input int sel);
        return (sel == 0) ? WC0 : WC1;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready0_s : ready1_s;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? err0_s : err1_s;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? rdata0_s : rdata1_s;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_s++;
        if (obs !== exp) begin
            bad_s++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            exp_rd[s]    = 32'h0000_0000;
            exp_rd_ok[s] = 1'b1;
        end
    endtask

    // One complete request/response; noise scrambles the inputs while the responder is busy.
    task automatic txn(input int sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit noise, output int rcyc);
        int n;
        int idx;
        bit mis;
        idx = int'((a / 32'd4) % DEPTH);
        mis = MIS_EN && ((a % 32'd4) != 32'd0);
        @(negedge clk_s);
        req_s[sel] = 1'b1; we_s[sel] = w; addr_s[sel] = a; wdata_s[sel] = d;
        @(posedge clk_s); #1;
        if (w) begin
            if (!mis) begin
                ref_mem[sel][idx] = d;
                ref_vld[sel][idx] = 1'b1;
            end
        end else if (mis) begin
            exp_rd[sel] = 32'h0000_0000;
            exp_rd_ok[sel] = 1'b1;
        end else begin
            exp_rd[sel] = ref_mem[sel][idx];
            exp_rd_ok[sel] = ref_vld[sel][idx];
        end
        n = 0;
        while (get_ready(sel) !== 1'b1 && n < 40) begin
            if (noise) begin
                addr_s[sel] = 32'h0000_0080; we_s[sel] = 1'b1; wdata_s[sel] = $urandom;
            end
            @(posedge clk_s); #1;
            n++;
        end
        rcyc = cyc_r;
        req_s[sel] = 1'b0;
        check_val($sformatf("latency%0d", sel), n, wc(sel));
        check_val($sformatf("err%0d", sel), get_err(sel), mis);
        if (exp_rd_ok[sel]) check_val($sformatf("rdata%0d", sel), get_rdata(sel), exp_rd[sel]);
        @(posedge clk_s); #1;
        check_val($sformatf("ready_pulse%0d", sel), get_ready(sel), 1'b0);
        check_val($sformatf("err_clear%0d", sel), get_err(sel), 1'b0);
        if (exp_rd_ok[sel]) check_val($sformatf("rdata_hold%0d", sel), get_rdata(sel), exp_rd[sel]);
    endtask

    initial begin
        int t1;
        int t2;
        int sel;
        int idx;
        logic [31:0] a;
        logic [31:0] lo;
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = 32'h0; wdata_s[s] = 32'h0;
            for (int i = 0; i < DEPTH; i++) ref_vld[s][i] = 1'b0;
        end
        model_reset();
        repeat (3) @(posedge clk_s);
        @(negedge clk_s); rst_s = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check_val("reset_ready", get_ready(s), 1'b0);
            check_val("reset_rdata", get_rdata(s), 32'h0000_0000);
            check_val("reset_err", get_err(s), 1'b0);
        end

        // Reset during the wait of a read: no response, RData stays cleared
        @(negedge clk_s);
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h0000_0010;
        @(posedge clk_s); #1;
        req_s[0] = 1'b0; rst_s = 1'b1;
        model_reset();
        @(posedge clk_s); #1;
        check_val("rst_ready", ready0_s, 1'b0);
        @(negedge clk_s); rst_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_s); #1;
            check_val("rst_no_resp", ready0_s, 1'b0);
        end
        check_val("rst_rdata", rdata0_s, 32'h0000_0000);

        // Reset after a write was accepted: the write stays committed
        @(negedge clk_s);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h0000_0020; wdata_s[0] = 32'hA5A5_0F0F;
        @(posedge clk_s); #1;
        req_s[0] = 1'b0; rst_s = 1'b1;
        ref_mem[0][8] = 32'hA5A5_0F0F; ref_vld[0][8] = 1'b1;
        model_reset();
        @(negedge clk_s); rst_s = 1'b0;
        txn(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, t1);

        txn(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, t1);
        txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, t1);
        txn(0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0, t1);
        txn(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, t1);

        // Inputs changed while busy must not disturb the word at 0x80
        txn(0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1'b0, t1);
        txn(0, 1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 1'b0, t1);
        txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, t1);
        txn(0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, t1);

        txn(0, 1'b1, 32'h0000_0040, 32'h1111_2222, 1'b0, t1);
        txn(0, 1'b1, 32'h0000_0042, 32'h3333_4444, 1'b0, t1);
        txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, t1);

        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b0, 32'h0000_0000, 32'h0, 1'b0, t1);
            txn(s, 1'b0, 32'h0000_0004, 32'h0, 1'b0, t2);
            check_val($sformatf("b2b%0d", s), t2 - t1, wc(s) + 2);
        end

        for (int i = 0; i < 64; i++) begin
            for (int s = 0; s < 2; s++) txn(s, 1'b1, 32'(i * 4), $urandom, 1'b0, t1);
        end

        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 1);
            idx = $urandom_range(0, 63);
            lo  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
            a   = ($urandom & 32'hFFFF_FC00) | 32'(idx * 4) | lo;
            txn(sel, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), t1);
        end

        $display("test done: total=%0d bad=%0d", total_s, bad_s);
        $finish;
    end
endmodule
